// File: rtl/pc_redirect_unit.sv
// ---------------------------------------------------------------------------
// pc_redirect_unit
//
// Purpose:
//   Fetch-side owner of the program counter. Consumes the resolved jump
//   target from the EX-stage jump selector, drives the instruction-memory
//   address, applies redirects and squashes wrong-path instructions by
//   holding IF/ID and ID/EX flushes for FLUSH_CYCLES unstalled cycles.
//   A redirect that arrives while the hazard unit stalls is parked and
//   applied when the stall releases.
//
// Interface (all timing relative to the rising edge of clk):
//   There is no valid/ready handshake here. j_req is a single-cycle pulse
//   that qualifies j_addr in the same cycle and is always accepted. stall
//   freezes the PC and the flush countdown. It never drops a request; a
//   request seen during stall is parked until the stall releases.
//
// Ports:
//   clk            in   1      system clock
//   rst_n          in   1      synchronous active-low reset
//   stall          in   1      hazard-unit stall; PC and flush count hold
//   j_req          in   1      jump taken this cycle (pulse from EX)
//   j_addr         in   32     resolved jump target, valid with j_req
//   imem_addr      out  32     current PC (registered)
//   pc_plus4       out  32     imem_addr + 4, combinational
//   if_valid       out  1      fetch at imem_addr is on the correct path
//   flush_if_id    out  1      synchronous clear of IF/ID
//   flush_id_ex    out  1      synchronous clear of ID/EX
//   redirect_busy  out  1      high while in HOLD or FLUSH
//   misalign_err   out  1      sticky, a target with [1:0] != 0 was seen
//   redirect_cnt   out  CNT_W  saturating count of applied redirects
//   dbg_state      out  2      current FSM state (RUN=0, HOLD=1, FLUSH=2)
// ---------------------------------------------------------------------------
module pc_redirect_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             j_req,
  input  logic [31:0]      j_addr,
  output logic [31:0]      imem_addr,
  output logic [31:0]      pc_plus4,
  output logic             if_valid,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             redirect_busy,
  output logic             misalign_err,
  output logic [CNT_W-1:0] redirect_cnt,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HOLD  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  // FLUSH_CYCLES is limited to 1..7, so a 3-bit countdown is enough.
  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES);

  state_t             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        pending_q, pending_d;
  logic [2:0]         cnt_q, cnt_d;
  logic               flush_q, flush_d;
  logic               if_valid_q, if_valid_d;
  logic               busy_q, busy_d;
  logic               misalign_q, misalign_d;
  logic [CNT_W-1:0]   redir_cnt_q, redir_cnt_d;

  logic [31:0]        target;
  logic [31:0]        pc_inc;
  logic               apply_redirect;

  // Low address bits are forced to zero; misalignment is only flagged.
  assign target = {j_addr[31:2], 2'b00};
  assign pc_inc = pc_q + 32'd4;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    pending_d      = pending_q;
    cnt_d          = cnt_q;
    apply_redirect = 1'b0;

    unique case (state_q)
      ST_RUN, ST_FLUSH: begin
        if (j_req) begin
          if (!stall) begin
            // Redirect now; a redirect during FLUSH restarts the countdown.
            pc_d           = target;
            cnt_d          = FLUSH_INIT;
            state_d        = ST_FLUSH;
            apply_redirect = 1'b1;
          end else begin
            pending_d = target;
            state_d   = ST_HOLD;
          end
        end else if (!stall) begin
          pc_d = pc_inc;
          if (state_q == ST_FLUSH) begin
            // The edge that consumes the last flush cycle returns to RUN,
            // so flushes are seen for exactly FLUSH_CYCLES unstalled cycles.
            if (cnt_q <= 3'd1) begin
              cnt_d   = 3'd0;
              state_d = ST_RUN;
            end else begin
              cnt_d = cnt_q - 3'd1;
            end
          end
        end
      end

      ST_HOLD: begin
        // Latest request wins, including one arriving on the release cycle.
        if (j_req) begin
          pending_d = target;
        end
        if (!stall) begin
          pc_d           = j_req ? target : pending_q;
          cnt_d          = FLUSH_INIT;
          state_d        = ST_FLUSH;
          apply_redirect = 1'b1;
        end
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Registered outputs are decoded from the next state so they line up
  // with the PC they describe.
  always_comb begin
    flush_d     = (state_d == ST_FLUSH);
    if_valid_d  = (state_d == ST_RUN);
    busy_d      = (state_d != ST_RUN);
    misalign_d  = misalign_q | (j_req & (j_addr[1:0] != 2'b00));
    redir_cnt_d = redir_cnt_q;
    if (apply_redirect && (redir_cnt_q != {CNT_W{1'b1}})) begin
      redir_cnt_d = redir_cnt_q + 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // State and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      pc_q        <= RESET_PC;
      pending_q   <= 32'd0;
      cnt_q       <= 3'd0;
      flush_q     <= 1'b0;
      if_valid_q  <= 1'b1;
      busy_q      <= 1'b0;
      misalign_q  <= 1'b0;
      redir_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pending_q   <= pending_d;
      cnt_q       <= cnt_d;
      flush_q     <= flush_d;
      if_valid_q  <= if_valid_d;
      busy_q      <= busy_d;
      misalign_q  <= misalign_d;
      redir_cnt_q <= redir_cnt_d;
    end
  end

  assign imem_addr     = pc_q;
  assign pc_plus4      = pc_inc;
  assign if_valid      = if_valid_q;
  assign flush_if_id   = flush_q;
  assign flush_id_ex   = flush_q;
  assign redirect_busy = busy_q;
  assign misalign_err  = misalign_q;
  assign redirect_cnt  = redir_cnt_q;
  assign dbg_state     = state_q;

endmodule
